acc_tx_bytes: RTL



---
 rtl/acc_tx_bytes_if.sv | 23 ++
 rtl/acc_tx_bytes.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/acc_tx_bytes_if.sv
// Byte-stream bundle between the accumulator snapshot serializer and the TX path.
// master = serializer side, slave = control/transmit side.
interface acc_tx_bytes_if #(
  parameter int DB = 16
);
  logic          Inicio;
  logic [DB-1:0] Entrada;
  logic          ListoSalida;
  logic [7:0]    Salida;
  logic          ValidSalida;
  logic          Ocupado;
  logic          Fin;

  modport master (
    input  Inicio, Entrada, ListoSalida,
    output Salida, ValidSalida, Ocupado, Fin
  );

  modport slave (
    output Inicio, Entrada, ListoSalida,
    input  Salida, ValidSalida, Ocupado, Fin
  );
endinterface

// File: rtl/acc_tx_bytes.sv
// Snapshots a DB-bit accumulator on Inicio and streams it LSB byte first over valid/ready.
// Optional trailing XOR checksum byte when ACC_TX_CHECKSUM_EN is defined.
module acc_tx_bytes #(
  parameter int DB = 16
) (
  input  logic           clk,
  input  logic           reset,
  acc_tx_bytes_if.master bus
);
  localparam int NBYTES = (DB + 7) / 8;
  localparam int W      = 8 * NBYTES;
`ifdef ACC_TX_CHECKSUM_EN
  localparam int NTOT   = NBYTES + 1;
`else
  localparam int NTOT   = NBYTES;
`endif
  localparam int CW     = (NTOT > 1) ? $clog2(NTOT) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NTOT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_FIN
  } state_t;

  state_t         r_state, w_state_next;
  logic [W-1:0]   r_shift, w_shift_next;
  logic [CW-1:0]  r_cnt, w_cnt_next;
  logic [7:0]     r_salida, w_salida_next;
  logic           r_valid, w_valid_next;
  logic           r_ocupado, w_ocupado_next;
  logic           r_fin, w_fin_next;

  logic [W-1:0]   w_ent_ext;
  logic [W-1:0]   w_shift_dn;
  logic           w_hs;

  assign w_ent_ext  = W'(bus.Entrada);
  assign w_shift_dn = r_shift >> 8;
  assign w_hs       = r_valid && bus.ListoSalida;

`ifdef ACC_TX_CHECKSUM_EN
  localparam logic [CW-1:0] DATA_LAST = CW'(NBYTES - 1);
  logic [7:0] r_csum, w_csum_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csum <= 8'h00;
    end else begin
      r_csum <= w_csum_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_salida  <= 8'h00;
      r_valid   <= 1'b0;
      r_ocupado <= 1'b0;
      r_fin     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_cnt     <= w_cnt_next;
      r_salida  <= w_salida_next;
      r_valid   <= w_valid_next;
      r_ocupado <= w_ocupado_next;
      r_fin     <= w_fin_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_cnt_next     = r_cnt;
    w_salida_next  = r_salida;
    w_valid_next   = r_valid;
    w_ocupado_next = r_ocupado;
    w_fin_next     = 1'b0;
`ifdef ACC_TX_CHECKSUM_EN
    w_csum_next    = r_csum;
`endif
    case (r_state)
      S_IDLE: begin
        w_salida_next  = 8'h00;
        w_valid_next   = 1'b0;
        w_ocupado_next = 1'b0;
        if (bus.Inicio) begin
          w_shift_next   = w_ent_ext;
          w_cnt_next     = '0;
          w_salida_next  = w_ent_ext[7:0];
          w_valid_next   = 1'b1;
          w_ocupado_next = 1'b1;
          w_state_next   = S_SEND;
`ifdef ACC_TX_CHECKSUM_EN
          w_csum_next    = 8'h00;
`endif
        end
      end
      S_SEND: begin
        // Without a handshake every output simply holds its registered value.
        if (w_hs) begin
          if (r_cnt == LAST_IDX) begin
            w_valid_next  = 1'b0;
            w_salida_next = 8'h00;
            w_fin_next    = 1'b1;
            w_state_next  = S_FIN;
          end else begin
            w_shift_next  = w_shift_dn;
            w_cnt_next    = r_cnt + 1'b1;
            w_salida_next = w_shift_dn[7:0];
`ifdef ACC_TX_CHECKSUM_EN
            w_csum_next   = r_csum ^ r_salida;
            if (r_cnt == DATA_LAST) begin
              w_salida_next = r_csum ^ r_salida;
            end
`endif
          end
        end
      end
      S_FIN: begin
        w_ocupado_next = 1'b0;
        w_state_next   = S_IDLE;
      end
      default: begin
        w_state_next   = S_IDLE;
        w_valid_next   = 1'b0;
        w_ocupado_next = 1'b0;
        w_salida_next  = 8'h00;
      end
    endcase
  end

  assign bus.Salida      = r_salida;
  assign bus.ValidSalida = r_valid;
  assign bus.Ocupado     = r_ocupado;
  assign bus.Fin         = r_fin;
endmodule
